ser_frame_tx: RTL and testbench

Parametrised, double-buffered parallel-to-serial converter for the UART/serial transmit path. It accepts a WIDTH-bit word through a valid/ready handshake and emits the bits one per `ser_en` strobe, LSB-first or MSB-first. An optional even/odd parity bit is appended, and the next word streams back-to-back with no idle gap. It sits between the transmit data source (FIFO or register-file read side) and the frame mux that adds start and stop bits.

---
 rtl/ser_frame_tx.sv | 166 ++++++++++++++++
 tb/tb_ser_frame_tx.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ser_frame_tx.sv
// ser_frame_tx: double-buffered parallel-to-serial shifter for the
// UART transmit path, with optional parity and back-to-back words.
//
// Ports:
//   CLK, RST          clock, asynchronous active-high reset
//   P_DATA            parallel word, taken when DATA_VALID && DATA_READY
//   DATA_VALID/READY  word handshake (READY = holding buffer empty)
//   MSB_FIRST         bit order, captured with the word
//   PAR_EN, PAR_TYP   parity enable / type (0 even, 1 odd), captured
//   ser_en            bit-advance strobe (baud tick)
//   ser_data          registered serial output, idles at 1
//   ser_done          one-cycle pulse after the last bit of a word
//   Busy              high while shifting data or parity
module ser_frame_tx #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] P_DATA,
  input  logic             DATA_VALID,
  output logic             DATA_READY,
  input  logic             MSB_FIRST,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  input  logic             ser_en,
  output logic             ser_data,
  output logic             ser_done,
  output logic             Busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] buf_data;
  logic             buf_msb;
  logic             buf_par;
  logic             buf_pen;
  logic             buf_full;

  logic [WIDTH-1:0] sh_data;
  logic             sh_msb;
  logic             sh_par;
  logic             sh_pen;
  logic [CNT_W-1:0] bit_cnt;

  logic accept;
  logic load;
  logic adv;
  logic to_par;
  logic eow;
  logic last_bit;

  assign accept   = DATA_VALID && !buf_full;
  assign last_bit = (bit_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // End of word reloads straight from the buffer so a
  // queued word follows with no idle bit in between.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    adv       = 1'b0;
    to_par    = 1'b0;
    eow       = 1'b0;
    unique case (state)
      IDLE: begin
        if (buf_full) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (ser_en) begin
          if (!last_bit) begin
            adv = 1'b1;
          end else if (sh_pen) begin
            to_par    = 1'b1;
            state_nxt = PARITY;
          end else begin
            eow = 1'b1;
          end
        end
      end
      PARITY: begin
        if (ser_en) eow = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    if (eow) begin
      if (buf_full) begin
        load      = 1'b1;
        state_nxt = SHIFT;
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  always_comb begin
    Busy       = (state != IDLE);
    DATA_READY = !buf_full;
  end

  // Parity is folded at acceptance so the mode pins are
  // never looked at again for this word.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      buf_data <= '0;
      buf_msb  <= 1'b0;
      buf_par  <= 1'b0;
      buf_pen  <= 1'b0;
      buf_full <= 1'b0;
    end else if (load) begin
      buf_full <= 1'b0;
    end else if (accept) begin
      buf_data <= P_DATA;
      buf_msb  <= MSB_FIRST;
      buf_pen  <= PAR_EN;
      buf_par  <= (^P_DATA) ^ PAR_TYP;
      buf_full <= 1'b1;
    end
  end

  // The next bit always sits at the shifter's edge chosen
  // by the captured order; the first one is peeled off on load.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sh_data  <= '0;
      sh_msb   <= 1'b0;
      sh_par   <= 1'b0;
      sh_pen   <= 1'b0;
      bit_cnt  <= '0;
      ser_data <= 1'b1;
      ser_done <= 1'b0;
    end else begin
      ser_done <= eow;
      if (load) begin
        sh_data  <= buf_msb ? (buf_data << 1) : (buf_data >> 1);
        sh_msb   <= buf_msb;
        sh_par   <= buf_par;
        sh_pen   <= buf_pen;
        bit_cnt  <= '0;
        ser_data <= buf_msb ? buf_data[WIDTH-1] : buf_data[0];
      end else if (adv) begin
        sh_data  <= sh_msb ? (sh_data << 1) : (sh_data >> 1);
        bit_cnt  <= bit_cnt + CNT_W'(1);
        ser_data <= sh_msb ? sh_data[WIDTH-1] : sh_data[0];
      end else if (to_par) begin
        ser_data <= sh_par;
      end else if (eow) begin
        ser_data <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ser_frame_tx.sv
// tb_ser_frame_tx: random and directed stimulus for ser_frame_tx,
// checked against a bit-stream reference queue.
module tb_ser_frame_tx;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST;
  logic [W-1:0] P_DATA;
  logic         DATA_VALID;
  logic         DATA_READY;
  logic         MSB_FIRST;
  logic         PAR_EN;
  logic         PAR_TYP;
  logic         ser_en;
  logic         ser_data;
  logic         ser_done;
  logic         Busy;

  ser_frame_tx #(.WIDTH(W), .CNT_W(4)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .DATA_READY (DATA_READY),
    .MSB_FIRST  (MSB_FIRST),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .ser_en     (ser_en),
    .ser_data   (ser_data),
    .ser_done   (ser_done),
    .Busy       (Busy)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ser_en generator: 0 = always, 1 = every 4th cycle, 2 = random
  int en_mode = 0;
  int div = 0;
  always @(posedge CLK) begin
    #1;
    div = (div + 1) % 4;
    if (en_mode == 0)      ser_en = 1'b1;
    else if (en_mode == 1) ser_en = (div == 0);
    else                   ser_en = 1'($urandom_range(0, 1));
  end

  // Reference: every accepted word expands into the exact bits the
  // line must carry; each ser_en edge while busy consumes one.
  typedef struct packed {
    logic b;
    logic last;
  } ex_t;

  ex_t exp_q[$];
  int  done_cyc[$];
  int  holds[$];
  int  cyc = 0;
  int  consumed = 0;
  int  n_acc = 0;
  int  falls = 0;
  int  hold = 0;
  logic done_due = 1'b0;
  logic done_nxt;
  logic prev_busy = 1'b0;

  always @(negedge CLK) begin
    ex_t e;
    cyc++;
    if (RST) begin
      exp_q.delete();
      done_due  = 1'b0;
      hold      = 0;
      prev_busy = 1'b0;
    end else begin
      chk("done_pulse", ser_done, done_due);
      done_nxt = 1'b0;
      if (ser_done) done_cyc.push_back(cyc);
      if (prev_busy && !Busy) falls++;
      prev_busy = Busy;
      if (!Busy) begin
        chk("idle_high", ser_data, 1);
        hold = 0;
      end else begin
        hold++;
        if (ser_en) begin
          consumed++;
          chk("exp_avail", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("ser_bit", ser_data, e.b);
            done_nxt = e.last;
          end
          holds.push_back(hold);
          hold = 0;
        end
      end
      done_due = done_nxt;
      if (DATA_VALID && DATA_READY) begin
        n_acc++;
        for (int k = 0; k < W; k++) begin
          e.b    = MSB_FIRST ? P_DATA[W-1-k] : P_DATA[k];
          e.last = (k == W - 1) && !PAR_EN;
          exp_q.push_back(e);
        end
        if (PAR_EN) begin
          e.b    = (^P_DATA) ^ PAR_TYP;
          e.last = 1'b1;
          exp_q.push_back(e);
        end
      end
    end
  end

  // Called and returns at posedge+1.
  task automatic send(input logic [W-1:0] d, input logic m,
                      input logic p, input logic t, input bit keep);
    int n;
    P_DATA     = d;
    MSB_FIRST  = m;
    PAR_EN     = p;
    PAR_TYP    = t;
    DATA_VALID = 1'b1;
    n = 0;
    while (!DATA_READY && n < 200) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("accept_wait", DATA_READY, 1);
    @(posedge CLK); #1;
    if (!keep) DATA_VALID = 1'b0;
  endtask

  // Returns at the negedge where ser_done is seen.
  task automatic wait_done(input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge CLK);
      if (ser_done) break;
    end
    chk("done_seen", ser_done, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0, a0, n;
    RST        = 1'b1;
    ser_en     = 1'b0;
    P_DATA     = '0;
    DATA_VALID = 1'b0;
    MSB_FIRST  = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    #2;
    chk("rst_data",  ser_data, 1);
    chk("rst_done",  ser_done, 0);
    chk("rst_busy",  Busy, 0);
    chk("rst_ready", DATA_READY, 1);
    @(posedge CLK); @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;

    // 8'h35 LSB-first, no parity, ser_en continuous
    en_mode = 0;
    send(8'h35, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lat_busy0", Busy, 0);
    @(posedge CLK); #1;
    chk("lat_busy1", Busy, 1);
    chk("lat_first", ser_data, 1);
    wait_done(40);
    chk("end_busy", Busy, 0);
    chk("end_data", ser_data, 1);
    @(posedge CLK); #1;

    // 8'h35 MSB-first with odd, then even parity
    send(8'h35, 1'b1, 1'b1, 1'b1, 1'b0);
    wait_done(40);
    @(posedge CLK); #1;
    send(8'h35, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_done(40);
    @(posedge CLK); #1;

    // back-to-back FF then 00
    falls = 0;
    done_cyc.delete();
    send(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    send(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rdy_after_acc", DATA_READY, 0);
    @(negedge CLK);
    for (n = 0; n < 20 && !ser_done; n++) begin
      chk("rdy_hold", DATA_READY, 0);
      @(negedge CLK);
    end
    chk("b2b_done1", ser_done, 1);
    chk("rdy_back", DATA_READY, 1);
    chk("b2b_busy", Busy, 1);
    wait_done(40);
    chk("b2b_idle", Busy, 0);
    @(posedge CLK); #1;
    chk("b2b_ndone", done_cyc.size(), 2);
    if (done_cyc.size() == 2)
      chk("b2b_gap", done_cyc[1] - done_cyc[0], 8);
    chk("b2b_falls", falls, 1);

    // ser_en every 4th cycle, modes toggled mid-word
    en_mode = 1;
    holds.delete();
    send(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    for (n = 0; n < 200; n++) begin
      @(negedge CLK);
      if (ser_done) break;
      MSB_FIRST = 1'($urandom_range(0, 1));
      PAR_EN    = 1'($urandom_range(0, 1));
      PAR_TYP   = 1'($urandom_range(0, 1));
      P_DATA    = W'($urandom);
    end
    chk("slow_done", ser_done, 1);
    @(posedge CLK); #1;
    chk("slow_nbits", holds.size(), 8);
    if (holds.size() >= 8)
      for (int i = 1; i < 8; i++) chk("hold4", holds[i], 4);

    // reset after the 3rd bit
    en_mode = 0;
    c0 = consumed;
    send(8'hC3, 1'b0, 1'b1, 1'b0, 1'b0);
    for (n = 0; n < 100 && consumed < c0 + 3; n++) begin
      @(negedge CLK); #1;
    end
    chk("rst_reach3", consumed - c0, 3);
    #1;
    RST = 1'b1;
    #1;
    chk("mid_rst_data",  ser_data, 1);
    chk("mid_rst_busy",  Busy, 0);
    chk("mid_rst_ready", DATA_READY, 1);
    chk("mid_rst_done",  ser_done, 0);
    @(posedge CLK); @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    chk("post_rst_done", ser_done, 0);
    send(8'h5A, 1'b1, 1'b1, 1'b1, 1'b0);
    wait_done(40);
    @(posedge CLK); #1;

    // 100 random words, DATA_VALID held, random ser_en
    en_mode = 2;
    a0 = n_acc;
    for (int i = 0; i < 100; i++)
      send(W'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    DATA_VALID = 1'b0;
    for (n = 0; n < 5000; n++) begin
      @(negedge CLK); #1;
      if (exp_q.size() == 0 && !Busy) break;
    end
    chk("rand_acc", n_acc - a0, 100);
    chk("drain_q", exp_q.size(), 0);
    chk("drain_busy", Busy, 0);
    @(posedge CLK); #1;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
